// File: rtl/capture_wr_buffer.sv
// Capture-side write buffer: FIFOs camera pixel writes and replays them to a
// stall-capable frame-buffer port over req/ack. Optional stats via CAPTURE_WR_STATS_EN.
module capture_wr_buffer #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 19,
   parameter int DATA_W = 24
) (
   input  logic                     iclk,
   input  logic                     ireset,
   input  logic                     iwr_en,
   input  logic [ADDR_W-1:0]        iaddr,
   input  logic [DATA_W-1:0]        idata,
   input  logic                     iclr_ovf,
   input  logic                     imem_ack,
   output logic                     omem_req,
   output logic [ADDR_W-1:0]        omem_addr,
   output logic [DATA_W-1:0]        omem_data,
   output logic [$clog2(DEPTH):0]   ofifo_level,
   output logic                     oovf
`ifdef CAPTURE_WR_STATS_EN
   ,
   output logic [15:0]              oframe_cnt,
   output logic [15:0]              odrop_cnt
`endif
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int ENTRY_W = ADDR_W + DATA_W;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_REQ  = 1'b1;

   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] ZERO_LVL = {LVL_W{1'b0}};
   localparam logic [LVL_W-1:0] ONE_LVL  = {{(LVL_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0] ONE_PTR  = {{(PTR_W-1){1'b0}}, 1'b1};

   logic [ENTRY_W-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [0:0]        state_q, state_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              ovf_q, ovf_d;

   logic              push_s;
   logic              drop_s;
   logic              pop_s;
   logic [ENTRY_W-1:0] head_s;

   assign head_s = mem_q[rd_ptr_q];

   // Push acceptance: a full FIFO always drops, even if a pop happens the same edge.
   always_comb begin
      push_s = 1'b0;
      drop_s = 1'b0;
      if (iwr_en) begin
         if (level_q == FULL_LVL) begin
            drop_s = 1'b1;
         end else begin
            push_s = 1'b1;
         end
      end else begin
         push_s = 1'b0;
      end
   end

   // Output FSM: loads the head into the output registers and holds it until acked.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      data_d  = data_q;
      pop_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (level_q != ZERO_LVL) begin
               pop_s   = 1'b1;
               {addr_d, data_d} = head_s;
               req_d   = 1'b1;
               state_d = ST_REQ;
            end else begin
               req_d   = 1'b0;
            end
         end
         ST_REQ: begin
            if (imem_ack) begin
               if (level_q != ZERO_LVL) begin
                  pop_s = 1'b1;
                  {addr_d, data_d} = head_s;
                  req_d = 1'b1;
               end else begin
                  req_d   = 1'b0;
                  state_d = ST_IDLE;
               end
            end else begin
               req_d = 1'b1;
            end
         end
         default: begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Pointer, level and sticky-overflow next state; overflow set beats clear.
   always_comb begin
      wr_ptr_d = push_s ? (wr_ptr_q + ONE_PTR) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + ONE_PTR) : rd_ptr_q;
      level_d  = level_q;
      if (push_s && !pop_s) begin
         level_d = level_q + ONE_LVL;
      end else if (pop_s && !push_s) begin
         level_d = level_q - ONE_LVL;
      end else begin
         level_d = level_q;
      end
      if (drop_s) begin
         ovf_d = 1'b1;
      end else if (iclr_ovf) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // FIFO storage; contents need no reset since the level counter gates every read.
   always_ff @(posedge iclk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= {iaddr, idata};
      end
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge iclk) begin
      if (ireset) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         level_q  <= ZERO_LVL;
         state_q  <= ST_IDLE;
         req_q    <= 1'b0;
         addr_q   <= {ADDR_W{1'b0}};
         data_q   <= {DATA_W{1'b0}};
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         state_q  <= state_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         ovf_q    <= ovf_d;
      end
   end

   assign omem_req    = req_q;
   assign omem_addr   = addr_q;
   assign omem_data   = data_q;
   assign ofifo_level = level_q;
   assign oovf        = ovf_q;

`ifdef CAPTURE_WR_STATS_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   // Saturating counters; a drop in the same cycle as a clear still counts.
   always_comb begin
      if (push_s && (iaddr == {ADDR_W{1'b0}}) && (frame_cnt_q != 16'hFFFF)) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
         frame_cnt_d = frame_cnt_q;
      end
      if (drop_s) begin
         drop_cnt_d = (drop_cnt_q != 16'hFFFF) ? (drop_cnt_q + 16'd1) : drop_cnt_q;
      end else if (iclr_ovf) begin
         drop_cnt_d = 16'd0;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   // Statistics registers.
   always_ff @(posedge iclk) begin
      if (ireset) begin
         frame_cnt_q <= 16'd0;
         drop_cnt_q  <= 16'd0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign oframe_cnt = frame_cnt_q;
   assign odrop_cnt  = drop_cnt_q;
`endif

endmodule

// File: doc/capture_wr_buffer.md
Name: capture_wr_buffer

Overview:
- Downstream of the OV7670 capture stage; consumes its pixel write strobe, 19-bit pixel address and 24-bit pixel data.
- Decouples bursty camera pixel writes from a slower, stall-capable frame-buffer memory port through a FIFO.
- Drives the frame-buffer write port with a req/ack handshake.
- Single clock domain: capture outputs are already synchronised to iclk before entry.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 4.
- ADDR_W, 19, pixel address width (640x480 fits).
- DATA_W, 24, pixel data width (RGB888).

Ports:
- iclk  input  1  system clock; all logic on rising edge.
- ireset  input  1  synchronous, active-high reset.
- iwr_en  input  1  pixel valid strobe from capture; one pixel per high cycle.
- iaddr  input  ADDR_W  pixel address, sampled with iwr_en.
- idata  input  DATA_W  pixel data, sampled with iwr_en.
- iclr_ovf  input  1  clears the sticky overflow flag.
- imem_ack  input  1  memory accepted the current request.
- omem_req  output  1  write request to frame-buffer memory.
- omem_addr  output  ADDR_W  write address, stable while omem_req=1.
- omem_data  output  DATA_W  write data, stable while omem_req=1.
- ofifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy, not counting the output register.
- oovf  output  1  sticky overflow: at least one pixel dropped.

Behaviour:
- Reset (ireset=1 at an edge):
  - omem_req=0, omem_addr=0, omem_data=0, ofifo_level=0, oovf=0.
  - FIFO pointers cleared; FSM enters IDLE.
  - Reset mid-request discards the pending request and all FIFO contents. No ack is expected afterwards; an ack arriving in IDLE is ignored.
- Push:
  - At an edge with iwr_en=1 and level<DEPTH, {iaddr,idata} is written; level increments.
  - If level==DEPTH, the pixel is dropped and oovf is set next cycle. This holds even if a pop happens the same edge: a push when full is always dropped.
- Pop/FSM, 2 states:
  - IDLE: omem_req=0. If level>0, pop the head into omem_addr/omem_data, set omem_req=1 and go to REQ.
  - REQ: omem_req=1; addr/data held. On imem_ack=1:
    - level>0: pop the next entry into the output registers; omem_req stays 1; stay in REQ (back-to-back, one transfer per cycle when ack is held high).
    - level==0: omem_req=0; go to IDLE.
  - Without ack: hold addr, data and req unchanged indefinitely.
- Simultaneous push and pop at one edge: level is unchanged, both actions take effect. Level never exceeds DEPTH or goes below 0.
- Latency: a pixel pushed into an empty FIFO at edge E0 appears with omem_req=1 after edge E1.
- Ordering: strict FIFO; addresses pass through unmodified; no data transformation.
- Pointers: log2(DEPTH)-bit pointers wrap modulo DEPTH; full/empty derived from the level counter.
- oovf: set on any dropped push. Cleared by iclr_ovf=1 or by reset; set has priority over clear in the same cycle.

Optional Feature:
- Macro: CAPTURE_WR_STATS_EN.
- When defined, adds two outputs:
  - oframe_cnt (16 bits): increments on each accepted push with iaddr==0.
  - odrop_cnt (16 bits): increments on each dropped push.
  - Both reset to 0, saturate at 16'hFFFF, and odrop_cnt clears with iclr_ovf.
- When undefined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset then a single push (addr=0x00005, data=0x123456) with imem_ack held 1 -> omem_req=1 after the 2nd edge with addr 0x00005 / data 0x123456, for exactly one cycle; ofifo_level returns to 0.
- 20 consecutive pushes (addr 0..19), imem_ack=0, DEPTH=16 -> 1 entry in the output register plus 15 in the FIFO... then level=16, pushes 17..19 dropped, oovf=1. Releasing ack drains addresses 0..16 in order.
- Continuous pushes with imem_ack=1 -> back-to-back requests one per cycle, level stays ≤1, oovf=0.
- Stalled request (ack=0 for 10 cycles) -> omem_addr/omem_data are bit-stable for all 10 cycles; on ack, the next entry appears the following cycle.
- ireset asserted while in REQ with level=5 -> next cycle omem_req=0, level=0, oovf=0; a subsequent ack is ignored.
- With CAPTURE_WR_STATS_EN: 3 frames starting at addr 0 plus 4 drops -> oframe_cnt=3, odrop_cnt=4; after iclr_ovf -> odrop_cnt=0, oframe_cnt=3.
